board_renderer: RTL and testbench
=================================

BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter VISIBLE_ROWS, default 20, SHALL set the number of board rows scanned per frame, counted from row 0 upward.
REQ-002 clock_framerate  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 resetn  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 flat_board  in  230  SHALL carry the settled board; row r occupies bits [10r+9:10r], bit c of that field is column c.
REQ-005 block1_x..block4_x  in  4 each; block1_y..block4_y  in  5 each  SHALL carry the active tetromino cell coordinates.
REQ-006 full_refresh  in  1  SHALL be a one-cycle request to emit every visible row on the next frame.
REQ-007 row_valid  out  1  SHALL flag a row update offered downstream.
REQ-008 row_ready  in  1  SHALL be the downstream acceptance signal.
REQ-009 row_index  out  5  SHALL carry the offered row number.
REQ-010 row_fixed  out  10  SHALL carry the settled cells of the offered row.
REQ-011 row_active  out  10  SHALL carry the active-tetromino cells of the offered row.
REQ-012 frame_done  out  1  SHALL pulse high for one cycle at the end of each frame scan.

Function
REQ-013 The FSM SHALL have states IDLE, CAPTURE, SCAN, EMIT and DONE.
REQ-014 IDLE SHALL go to CAPTURE on the next cycle unconditionally.
REQ-015 CAPTURE (1 cycle) SHALL latch rows 0..VISIBLE_ROWS-1 of flat_board and a 10-bit active mask per row into snapshot registers, clear the row pointer, copy refresh_pending into frame_force, and clear refresh_pending.
REQ-016 Active mask bit c of row r SHALL be set iff some block n has block_n_y==r and block_n_x==c; blocks with y>=VISIBLE_ROWS or x>9 SHALL be ignored.
REQ-017 A row SHALL be dirty iff {fixed,active} of the snapshot differs from the shadow copy for that row, or frame_force is set.
REQ-018 In SCAN (1 cycle per row), a dirty row SHALL go to EMIT; a clean row SHALL increment the pointer, or go to DONE if the pointer equals VISIBLE_ROWS-1.
REQ-019 In EMIT, row_valid SHALL be 1 and row_index/row_fixed/row_active SHALL be registered values, held stable until row_valid and row_ready are both high.
REQ-020 On handshake, the shadow for that row SHALL be updated, and the FSM SHALL return to SCAN with the pointer incremented, or go to DONE after the last row.
REQ-021 row_ready SHALL be ignored outside EMIT; row_valid SHALL be 0 in every other state.
REQ-022 DONE SHALL assert frame_done for exactly one cycle, clear frame_force, and go to IDLE.
REQ-023 A full_refresh seen in any state SHALL set refresh_pending and apply to the next CAPTURE; the frame in progress SHALL be unaffected.
REQ-024 Inputs changing during SCAN or EMIT SHALL NOT affect the frame in progress.
REQ-025 Minimum frame length with no dirty rows SHALL be VISIBLE_ROWS+3 cycles.

Reset
REQ-026 While resetn is 0: state IDLE, pointer 0, all shadows 0, refresh_pending 1, frame_force 0, row_valid 0, frame_done 0, row_index/row_fixed/row_active 0.
REQ-027 Reset asserted during EMIT SHALL drop row_valid in the next cycle; the pending row SHALL be discarded.
REQ-028 The first frame after reset SHALL emit all VISIBLE_ROWS rows.

Configuration
REQ-029 With macro RENDER_DIRTY_ROWS_EN defined, only dirty rows SHALL be emitted per REQ-017; shadow registers SHALL exist.
REQ-030 Without RENDER_DIRTY_ROWS_EN, every row SHALL be treated as dirty every frame; shadow registers and full_refresh logic SHALL be omitted, and full_refresh SHALL be ignored.

Verification
REQ-031 Reset, empty board, row_ready=1 -> 20 handshakes with row_index 0..19 and row_fixed=0, then frame_done pulses once.
REQ-032 Second frame, inputs unchanged -> no row_valid; frame_done 23 cycles after the previous IDLE.
REQ-033 Active blocks (4,19),(3,19),(5,19),(4,18) -> rows 18 and 19 emitted; row 19 row_active=10'b0000111000, row 18 row_active=10'b0000010000.
REQ-034 row_ready held 0 for 5 cycles during EMIT -> row_valid, row_index and row_fixed constant for all 5 cycles; handshake on the 6th cycle.
REQ-035 full_refresh pulsed mid-frame -> current frame unchanged; next frame emits all 20 rows.
REQ-036 One block at y=21 and flat_board row 21 nonzero, otherwise unchanged -> no rows emitted.

Source files
------------

// File: rtl/board_renderer.sv
// board_renderer: scans a snapshot of the settled board plus the active
// tetromino once per frame and offers row updates over a valid/ready
// handshake, with a one-cycle frame_done pulse at the end of each scan.
//
// Build option: define RENDER_DIRTY_ROWS_EN to keep per-row shadow copies
// and emit only rows that changed since they were last accepted (or all
// rows after a full_refresh request). Without it every row is emitted
// every frame and full_refresh has no effect.
module board_renderer #(
    parameter int unsigned VISIBLE_ROWS = 20
) (
    input  logic         clock_framerate,
    input  logic         resetn,
    input  logic [229:0] flat_board,
    input  logic [3:0]   block1_x,
    input  logic [3:0]   block2_x,
    input  logic [3:0]   block3_x,
    input  logic [3:0]   block4_x,
    input  logic [4:0]   block1_y,
    input  logic [4:0]   block2_y,
    input  logic [4:0]   block3_y,
    input  logic [4:0]   block4_y,
    input  logic         full_refresh,
    input  logic         row_ready,
    output logic         row_valid,
    output logic [4:0]   row_index,
    output logic [9:0]   row_fixed,
    output logic [9:0]   row_active,
    output logic         frame_done
);

    localparam int unsigned ROW_W    = 10;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned X_W      = 4;
    localparam int unsigned NBLK     = 4;
    localparam int unsigned LAST_ROW = VISIBLE_ROWS - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SCAN    = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_n;

    logic                 valid_n;
    logic [IDX_W-1:0]     index_n;
    logic [ROW_W-1:0]     fixed_n;
    logic [ROW_W-1:0]     active_n;
    logic                 done_n;

    logic                 capture_en;
    logic                 row_accept;
    logic                 last_row;
    logic                 row_dirty;

    logic [X_W-1:0]       blk_x [NBLK];
    logic [IDX_W-1:0]     blk_y [NBLK];

    logic [ROW_W-1:0]     live_active [VISIBLE_ROWS];
    logic [ROW_W-1:0]     snap_fixed  [VISIBLE_ROWS];
    logic [ROW_W-1:0]     snap_active [VISIBLE_ROWS];

    assign blk_x[0] = block1_x;
    assign blk_x[1] = block2_x;
    assign blk_x[2] = block3_x;
    assign blk_x[3] = block4_x;
    assign blk_y[0] = block1_y;
    assign blk_y[1] = block2_y;
    assign blk_y[2] = block3_y;
    assign blk_y[3] = block4_y;

    assign last_row = (ptr == IDX_W'(LAST_ROW));

    // Per-row active mask; off-board blocks never match a visible row/column
    always_comb begin
        for (int unsigned r = 0; r < VISIBLE_ROWS; r++) begin
            live_active[r] = '0;
            for (int unsigned c = 0; c < ROW_W; c++) begin
                for (int unsigned n = 0; n < NBLK; n++) begin
                    live_active[r][c] = live_active[r][c]
                                      | ((blk_y[n] == IDX_W'(r)) && (blk_x[n] == X_W'(c)));
                end
            end
        end
    end

    // Frame snapshot, frozen for the rest of the scan
    always_ff @(posedge clock_framerate) begin
        if (capture_en) begin
            for (int unsigned r = 0; r < VISIBLE_ROWS; r++) begin
                snap_fixed[r]  <= flat_board[ROW_W*r +: ROW_W];
                snap_active[r] <= live_active[r];
            end
        end
    end

`ifdef RENDER_DIRTY_ROWS_EN
    logic [2*ROW_W-1:0] shadow [VISIBLE_ROWS];
    logic               refresh_pending;
    logic               frame_force;
    logic               unused_board;

    assign unused_board = ^flat_board;
    assign row_dirty    = frame_force
                        || ({snap_fixed[ptr], snap_active[ptr]} != shadow[ptr]);

    // Shadow of the last accepted contents per row, plus refresh bookkeeping
    always_ff @(posedge clock_framerate) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < VISIBLE_ROWS; r++) begin
                shadow[r] <= '0;
            end
            refresh_pending <= 1'b1;
            frame_force     <= 1'b0;
        end else begin
            if (row_accept) begin
                shadow[ptr] <= {snap_fixed[ptr], snap_active[ptr]};
            end
            // A request arriving during CAPTURE still lands in the next frame
            refresh_pending <= full_refresh | (refresh_pending & ~capture_en);
            if (capture_en) begin
                frame_force <= refresh_pending;
            end else if (state == DONE) begin
                frame_force <= 1'b0;
            end
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{flat_board, full_refresh, row_accept};
    assign row_dirty     = 1'b1;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        valid_n    = 1'b0;
        index_n    = row_index;
        fixed_n    = row_fixed;
        active_n   = row_active;
        done_n     = 1'b0;
        capture_en = 1'b0;
        row_accept = 1'b0;

        case (state)
            IDLE: begin
                state_n = CAPTURE;
            end
            CAPTURE: begin
                capture_en = 1'b1;
                ptr_n      = '0;
                state_n    = SCAN;
            end
            SCAN: begin
                if (row_dirty) begin
                    state_n  = EMIT;
                    valid_n  = 1'b1;
                    index_n  = ptr;
                    fixed_n  = snap_fixed[ptr];
                    active_n = snap_active[ptr];
                end else if (last_row) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    ptr_n = ptr + IDX_W'(1);
                end
            end
            EMIT: begin
                valid_n = 1'b1;
                if (row_ready) begin
                    row_accept = 1'b1;
                    valid_n    = 1'b0;
                    if (last_row) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SCAN;
                        ptr_n   = ptr + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs
    always_ff @(posedge clock_framerate) begin
        if (!resetn) begin
            state      <= IDLE;
            ptr        <= '0;
            row_valid  <= 1'b0;
            row_index  <= '0;
            row_fixed  <= '0;
            row_active <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            row_valid  <= valid_n;
            row_index  <= index_n;
            row_fixed  <= fixed_n;
            row_active <= active_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer; expectations follow the build option
// RENDER_DIRTY_ROWS_EN (dirty-row emission) or its absence (all rows).
`timescale 1ns/1ps
module tb_board_renderer;

`ifdef RENDER_DIRTY_ROWS_EN
    localparam bit DIRTY = 1'b1;
`else
    localparam bit DIRTY = 1'b0;
`endif

    logic         clock_framerate = 1'b0;
    logic         resetn          = 1'b0;
    logic [229:0] flat_board      = '0;
    logic [3:0]   block1_x = 4'd0, block2_x = 4'd0, block3_x = 4'd0, block4_x = 4'd0;
    logic [4:0]   block1_y = 5'd31, block2_y = 5'd31, block3_y = 5'd31, block4_y = 5'd31;
    logic         full_refresh    = 1'b0;
    logic         row_ready       = 1'b0;
    logic         row_valid;
    logic [4:0]   row_index;
    logic [9:0]   row_fixed;
    logic [9:0]   row_active;
    logic         frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    int          n_emit;
    int          cycles;
    bit          timeout;
    logic [4:0]  e_idx [64];
    logic [9:0]  e_fix [64];
    logic [9:0]  e_act [64];

    board_renderer #(.VISIBLE_ROWS(20)) dut (
        .clock_framerate (clock_framerate),
        .resetn          (resetn),
        .flat_board      (flat_board),
        .block1_x        (block1_x),
        .block2_x        (block2_x),
        .block3_x        (block3_x),
        .block4_x        (block4_x),
        .block1_y        (block1_y),
        .block2_y        (block2_y),
        .block3_y        (block3_y),
        .block4_y        (block4_y),
        .full_refresh    (full_refresh),
        .row_ready       (row_ready),
        .row_valid       (row_valid),
        .row_index       (row_index),
        .row_fixed       (row_fixed),
        .row_active      (row_active),
        .frame_done      (frame_done)
    );

    always #5 clock_framerate = ~clock_framerate;

    // Run until frame_done, logging handshakes; optional mid-frame pulse/board change
    task automatic collect(input int pulse_at, input int chg_at);
        n_emit  = 0;
        cycles  = 0;
        timeout = 1'b0;
        while (1) begin
            @(negedge clock_framerate);
            cycles++;
            if (row_valid && row_ready && n_emit < 64) begin
                e_idx[n_emit] = row_index;
                e_fix[n_emit] = row_fixed;
                e_act[n_emit] = row_active;
                n_emit++;
            end
            if (frame_done) break;
            if (cycles >= 400) begin
                timeout = 1'b1;
                break;
            end
            full_refresh = (cycles == pulse_at);
            if (cycles == chg_at) flat_board[100 +: 10] = 10'h155;
        end
        full_refresh = 1'b0;
    endtask

    function automatic logic [9:0] get_act(input int idx);
        for (int i = 0; i < n_emit; i++) if (int'(e_idx[i]) == idx) return e_act[i];
        return 10'bx;
    endfunction

    function automatic logic [9:0] get_fix(input int idx);
        for (int i = 0; i < n_emit; i++) if (int'(e_idx[i]) == idx) return e_fix[i];
        return 10'bx;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock_framerate);
        tests_run++; if (row_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", row_valid); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", frame_done); end
        tests_run++; if (row_index !== 5'd0) begin tests_failed++; $display("FAIL reset_index got %0d want 0", row_index); end
        tests_run++; if (row_fixed !== 10'd0) begin tests_failed++; $display("FAIL reset_fixed got %h want 0", row_fixed); end
        tests_run++; if (row_active !== 10'd0) begin tests_failed++; $display("FAIL reset_active got %h want 0", row_active); end
    endtask

    task automatic test_first_frame();
        int bad;
        resetn    = 1'b1;
        row_ready = 1'b1;
        collect(0, 0);
        bad = 0;
        for (int i = 0; i < n_emit; i++)
            if (e_idx[i] !== 5'(i) || e_fix[i] !== 10'd0 || e_act[i] !== 10'd0) bad++;
        tests_run++; if (timeout) begin tests_failed++; $display("FAIL first_timeout got timeout want frame_done"); end
        tests_run++; if (n_emit != 20) begin tests_failed++; $display("FAIL first_count got %0d want 20", n_emit); end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL first_rows got %0d bad entries want 0", bad); end
        tests_run++; if (cycles != 42) begin tests_failed++; $display("FAIL first_len got %0d want 42", cycles); end
    endtask

    task automatic test_steady();
        collect(0, 0);
        tests_run++; if (timeout) begin tests_failed++; $display("FAIL steady_timeout got timeout want frame_done"); end
        tests_run++; if (n_emit != (DIRTY ? 0 : 20)) begin tests_failed++; $display("FAIL steady_count got %0d want %0d", n_emit, DIRTY ? 0 : 20); end
        tests_run++; if (cycles != (DIRTY ? 23 : 43)) begin tests_failed++; $display("FAIL steady_len got %0d want %0d", cycles, DIRTY ? 23 : 43); end
    endtask

    task automatic test_active();
        block1_x = 4'd4; block1_y = 5'd19;
        block2_x = 4'd3; block2_y = 5'd19;
        block3_x = 4'd5; block3_y = 5'd19;
        block4_x = 4'd4; block4_y = 5'd18;
        collect(0, 0);
        tests_run++; if (n_emit != (DIRTY ? 2 : 20)) begin tests_failed++; $display("FAIL active_count got %0d want %0d", n_emit, DIRTY ? 2 : 20); end
        tests_run++; if (e_idx[0] !== (DIRTY ? 5'd18 : 5'd0)) begin tests_failed++; $display("FAIL active_first got %0d want %0d", e_idx[0], DIRTY ? 18 : 0); end
        tests_run++; if (get_act(19) !== 10'b0000111000) begin tests_failed++; $display("FAIL active_row19 got %b want 0000111000", get_act(19)); end
        tests_run++; if (get_act(18) !== 10'b0000010000) begin tests_failed++; $display("FAIL active_row18 got %b want 0000010000", get_act(18)); end
        tests_run++; if (cycles != (DIRTY ? 25 : 43)) begin tests_failed++; $display("FAIL active_len got %0d want %0d", cycles, DIRTY ? 25 : 43); end
    endtask

    task automatic test_backpressure();
        int          w;
        int          unstable;
        logic [4:0]  exp_idx;
        logic [9:0]  exp_fix;
        exp_idx = DIRTY ? 5'd5 : 5'd0;
        exp_fix = DIRTY ? 10'h2A5 : 10'h000;
        flat_board[50 +: 10] = 10'h2A5;
        row_ready = 1'b0;
        w = 0;
        do begin @(negedge clock_framerate); w++; end while (!row_valid && w < 200);
        tests_run++; if (row_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid got %b want 1", row_valid); end
        tests_run++; if (row_index !== exp_idx) begin tests_failed++; $display("FAIL bp_index got %0d want %0d", row_index, exp_idx); end
        tests_run++; if (row_fixed !== exp_fix) begin tests_failed++; $display("FAIL bp_fixed got %h want %h", row_fixed, exp_fix); end
        unstable = 0;
        for (int i = 2; i <= 6; i++) begin
            @(negedge clock_framerate);
            if (row_valid !== 1'b1 || row_index !== exp_idx || row_fixed !== exp_fix) unstable++;
        end
        tests_run++; if (unstable != 0) begin tests_failed++; $display("FAIL bp_hold got %0d unstable cycles want 0", unstable); end
        row_ready = 1'b1;
        @(negedge clock_framerate);
        tests_run++; if (row_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release got %b want 0", row_valid); end
        collect(0, 0);
        tests_run++; if (n_emit != (DIRTY ? 0 : 19)) begin tests_failed++; $display("FAIL bp_rest got %0d want %0d", n_emit, DIRTY ? 0 : 19); end
    endtask

    task automatic test_full_refresh();
        collect(5, 0);
        tests_run++; if (n_emit != (DIRTY ? 0 : 20)) begin tests_failed++; $display("FAIL fr_current got %0d want %0d", n_emit, DIRTY ? 0 : 20); end
        collect(0, 0);
        tests_run++; if (n_emit != 20) begin tests_failed++; $display("FAIL fr_next got %0d want 20", n_emit); end
        tests_run++; if (cycles != 43) begin tests_failed++; $display("FAIL fr_len got %0d want 43", cycles); end
    endtask

    task automatic test_input_change();
        int hits;
        collect(0, 5);
        hits = 0;
        for (int i = 0; i < n_emit; i++) if (e_fix[i] === 10'h155) hits++;
        tests_run++; if (n_emit != (DIRTY ? 0 : 20)) begin tests_failed++; $display("FAIL chg_current got %0d want %0d", n_emit, DIRTY ? 0 : 20); end
        tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL chg_leak got %0d rows with new data want 0", hits); end
        collect(0, 0);
        tests_run++; if (n_emit != (DIRTY ? 1 : 20)) begin tests_failed++; $display("FAIL chg_next got %0d want %0d", n_emit, DIRTY ? 1 : 20); end
        tests_run++; if (get_fix(10) !== 10'h155) begin tests_failed++; $display("FAIL chg_row10 got %h want 155", get_fix(10)); end
    endtask

    task automatic test_offboard();
        block4_x = 4'd4; block4_y = 5'd31;
        collect(0, 0);
        tests_run++; if (n_emit != (DIRTY ? 1 : 20)) begin tests_failed++; $display("FAIL off_settle got %0d want %0d", n_emit, DIRTY ? 1 : 20); end
        tests_run++; if (get_act(18) !== 10'd0) begin tests_failed++; $display("FAIL off_row18 got %b want 0", get_act(18)); end
        block4_x = 4'd2; block4_y = 5'd21;
        flat_board[210 +: 10] = 10'h3FF;
        collect(0, 0);
        tests_run++; if (n_emit != (DIRTY ? 0 : 20)) begin tests_failed++; $display("FAIL off_count got %0d want %0d", n_emit, DIRTY ? 0 : 20); end
        tests_run++; if (cycles != (DIRTY ? 23 : 43)) begin tests_failed++; $display("FAIL off_len got %0d want %0d", cycles, DIRTY ? 23 : 43); end
    endtask

    task automatic test_reset_during_emit();
        int w;
        row_ready    = 1'b0;
        full_refresh = 1'b1;
        @(negedge clock_framerate);
        full_refresh = 1'b0;
        w = 0;
        do begin @(negedge clock_framerate); w++; end while (!row_valid && w < 200);
        tests_run++; if (row_valid !== 1'b1) begin tests_failed++; $display("FAIL rde_valid got %b want 1", row_valid); end
        resetn = 1'b0;
        @(negedge clock_framerate);
        tests_run++; if (row_valid !== 1'b0) begin tests_failed++; $display("FAIL rde_drop got %b want 0", row_valid); end
        tests_run++; if (row_index !== 5'd0 || row_fixed !== 10'd0) begin tests_failed++; $display("FAIL rde_clear got idx %0d fixed %h want 0 0", row_index, row_fixed); end
        @(negedge clock_framerate);
        resetn    = 1'b1;
        row_ready = 1'b1;
        collect(0, 0);
        tests_run++; if (n_emit != 20) begin tests_failed++; $display("FAIL rde_count got %0d want 20", n_emit); end
        tests_run++; if (cycles != 42) begin tests_failed++; $display("FAIL rde_len got %0d want 42", cycles); end
        tests_run++; if (get_fix(5) !== 10'h2A5) begin tests_failed++; $display("FAIL rde_row5 got %h want 2a5", get_fix(5)); end
        tests_run++; if (get_act(19) !== 10'b0000111000) begin tests_failed++; $display("FAIL rde_row19 got %b want 0000111000", get_act(19)); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_steady();
        test_active();
        test_backpressure();
        test_full_refresh();
        test_input_change();
        test_offboard();
        test_reset_during_emit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog");
    end

endmodule
